rob_multiport: RTL and testbench
================================

# rob_multiport

Parametrised reorder buffer between dispatch, the execution write-back buses and the register file / instruction fetch. It accepts one allocation per cycle and any number of write-back ports. It retires up to COMMIT_W consecutive ready entries in program order per cycle. On a committed mispredicted branch it raises a redirect and flushes itself in the same edge.

## Interface
- DEPTH, 16: entry count, power of two, ≥4.
- WB_PORTS, 2: number of write-back ports.
- COMMIT_W, 2: maximum retirements per cycle, 1..4.
- DATA_W, 32: result width.
- ADDR_W, 32: PC width.
- REG_W, 5: architectural register index width.
- ID_W, log2(DEPTH)+1: ROB id width. id = index+1; id 0 means "no entry".
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_rd  in  REG_W  destination register.
- alloc_is_store  in  1  entry is a store.
- alloc_ready  out  1  buffer can accept an allocation this cycle.
- alloc_id  out  ID_W  id the next allocation receives.
- q1_id, q2_id  in  ID_W  operand producer ids to look up.
- q1_ready, q2_ready  out  1  the queried result is available.
- q1_data, q2_data  out  DATA_W  the queried result.
- wb_valid  in  WB_PORTS  per-port write-back strobe.
- wb_id  in  WB_PORTS*ID_W  packed ids, port 0 in the LSBs.
- wb_data  in  WB_PORTS*DATA_W  packed results.
- wb_jump  in  WB_PORTS  per-port mispredict flag.
- wb_target  in  WB_PORTS*ADDR_W  packed correct PCs.
- st_ready_valid, st_ready_id  in  1, ID_W  the store unit marks a store ready to retire.
- commit_valid  out  COMMIT_W  per-slot retire strobe, slot 0 oldest.
- commit_rd  out  COMMIT_W*REG_W  packed destination registers.
- commit_id  out  COMMIT_W*ID_W  packed ids.
- commit_data  out  COMMIT_W*DATA_W  packed results.
- commit_is_store  out  COMMIT_W  per-slot store flag.
- redirect_valid  out  1  one-cycle redirect pulse to fetch.
- redirect_pc  out  ADDR_W  redirect target.

## Operation
- State:
  - Circular queue with head, tail and a count of width log2(DEPTH)+1.
  - Per-entry fields: busy, ready, rd, data, jump, target, is_store.
- Allocation:
  - alloc_ready = (count < DEPTH).
  - When alloc_valid && alloc_ready: write tail with busy=1, ready=0 and data/jump/target cleared; advance tail.
  - alloc_valid while full has no effect.
  - alloc_id = tail+1 at all times.
- Write-back:
  - A valid port whose target entry is busy sets ready and stores data, jump and target.
  - A write-back to a non-busy entry, or to id 0, is ignored.
  - If two ports hit the same id, the highest-numbered port wins.
- Store ready: st_ready_valid on a busy entry sets ready only; data is unchanged.
- Operand lookup is combinational:
  - Id 0 gives ready=0, data=0.
  - Otherwise a same-cycle write-back hit on the id is bypassed (ready=1, data from that port).
  - Failing that, the entry's own ready and data are returned.
- Retirement: the retire group is the longest run of entries from head, up to COMMIT_W, that are busy && ready. It ends early:
  - after the first entry with jump=1, which is included;
  - before a second store.
- Pointer wrap: head and tail wrap modulo DEPTH.
- Count update: count_next = count + alloc_accepted − retired.
- Flush: when the retire group contains a jump entry, the same edge does all of the following:
  - registers the redirect (redirect_valid=1, redirect_pc=target);
  - clears every busy/ready bit, head, tail and count;
  - discards that cycle's allocation and write-backs.

## Timing
- Reset values:
  - all commit_* outputs 0, redirect_valid 0, redirect_pc 0;
  - head = tail = count = 0;
  - hence alloc_ready=1 and alloc_id=1.
- Write-back to retire latency: an entry written back at edge N that is at head retires at edge N+1, and commit_* is visible after N+1.
- commit_* and redirect_* are registered. commit_valid is low in any cycle with no retirement.
- redirect_valid is high for exactly one cycle. The first allocation after a flush receives id 1.
- Allocation feedback: an allocation at edge N is reflected in alloc_ready and alloc_id after N.
- Full with a simultaneous retire: alloc_ready is still 0 that cycle because it is computed from registered count (no same-cycle credit).
- rst mid-operation overrides everything, including a pending redirect.

## Structure
- Shared defines header: ZERO_ROB_ID, ROB id width rule, and packed-port slice macros.
- Sub-module rob_retire_select: combinational. Takes the head-window busy/ready/jump/is_store bits and returns the retire count and the jump slot.

## Test plan
- Reset, then allocate 16 entries with no write-back → alloc_ready=0 after the 16th; the 17th allocation is ignored and alloc_id stays 1 (tail wrapped).
- Allocate ids 1–3, write back 3 then 2 then 1 on port 0 with data 0x30/0x20/0x10 → no commit until id 1 is ready; then ids 1 and 2 retire in one cycle (commit_valid=2'b11, commit_data 0x10/0x20), and id 3 retires next cycle.
- Query q1_id=2 while port 1 writes back id 2 with data 0xABCD in the same cycle → q1_ready=1, q1_data=0xABCD combinationally.
- Allocate ids 1–4 and write back id 2 with jump=1, target 0x1000, all ready → ids 1 and 2 retire, redirect_valid=1, redirect_pc=0x1000; the next cycle count=0 and alloc_id=1.
- Two adjacent stores made ready via st_ready_valid → they retire in consecutive cycles, commit_is_store=1 each.
- Assert rst while 5 entries are ready at head → no commit_valid the following cycle, alloc_id=1.

Source files
------------

// File: rtl/rob_multiport_pkg.sv
// rob_multiport shared types and constants.
// ROB ids are index+1 so that id 0 can mean "no producer".
package rob_multiport_pkg;

  localparam int ZERO_ROB_ID = 0;
  localparam int MAX_COMMIT_W = 4;

  typedef logic [2:0] ret_cnt_t;

  function automatic int rob_id_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Picks how many head-window entries retire this cycle.
// A jump closes the group; a second store is held back.
module rob_retire_select
  import rob_multiport_pkg::*;
#(
  parameter int COMMIT_W = 2
) (
  input  logic [COMMIT_W-1:0] busy,
  input  logic [COMMIT_W-1:0] ready,
  input  logic [COMMIT_W-1:0] jump,
  input  logic [COMMIT_W-1:0] is_store,
  output ret_cnt_t            ret_cnt,
  output logic                jump_hit,
  output logic [1:0]          jump_slot
);

  logic done;
  logic st_seen;

  always_comb begin
    ret_cnt   = '0;
    jump_hit  = 1'b0;
    jump_slot = '0;
    done      = 1'b0;
    st_seen   = 1'b0;
    for (int s = 0; s < COMMIT_W; s++) begin
      if (!done) begin
        if (busy[s] && ready[s] &&
            !(is_store[s] && st_seen)) begin
          ret_cnt = ret_cnt_t'(s + 1);
          if (is_store[s]) st_seen = 1'b1;
          if (jump[s]) begin
            jump_hit  = 1'b1;
            jump_slot = 2'(s);
            done      = 1'b1;
          end
        end else begin
          done = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: single allocate, multi-port write-back,
// in-order multi-retire and flush on a committed mispredict.
module rob_multiport
  import rob_multiport_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WB_PORTS = 2,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int ID_W     = rob_id_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [REG_W-1:0]             alloc_rd,
  input  logic                         alloc_is_store,
  output logic                         alloc_ready,
  output logic [ID_W-1:0]              alloc_id,
  input  logic [ID_W-1:0]              q1_id,
  input  logic [ID_W-1:0]              q2_id,
  output logic                         q1_ready,
  output logic                         q2_ready,
  output logic [DATA_W-1:0]            q1_data,
  output logic [DATA_W-1:0]            q2_data,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*ID_W-1:0]     wb_id,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_data,
  input  logic [WB_PORTS-1:0]          wb_jump,
  input  logic [WB_PORTS*ADDR_W-1:0]   wb_target,
  input  logic                         st_ready_valid,
  input  logic [ID_W-1:0]              st_ready_id,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*REG_W-1:0]    commit_rd,
  output logic [COMMIT_W*ID_W-1:0]     commit_id,
  output logic [COMMIT_W*DATA_W-1:0]   commit_data,
  output logic [COMMIT_W-1:0]          commit_is_store,
  output logic                         redirect_valid,
  output logic [ADDR_W-1:0]            redirect_pc
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [IDX_W:0]    count;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  jump;
  logic [DEPTH-1:0]  is_store;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] tgt_q  [DEPTH];

  logic [IDX_W-1:0]    win_idx [COMMIT_W];
  logic [COMMIT_W-1:0] w_busy;
  logic [COMMIT_W-1:0] w_ready;
  logic [COMMIT_W-1:0] w_jump;
  logic [COMMIT_W-1:0] w_store;
  ret_cnt_t            ret_cnt;
  logic                jump_hit;
  logic [1:0]          jump_slot;
  logic [ADDR_W-1:0]   redir_pc;
  logic                alloc_ok;

  assign alloc_ready = count < (IDX_W+1)'(DEPTH);
  assign alloc_id    = ID_W'({1'b0, tail}) + ID_W'(1);
  assign alloc_ok    = alloc_valid && alloc_ready;

  always_comb begin
    redir_pc = '0;
    for (int s = 0; s < COMMIT_W; s++) begin
      win_idx[s] = head + IDX_W'(s);
      w_busy[s]  = busy[win_idx[s]];
      w_ready[s] = ready[win_idx[s]];
      w_jump[s]  = jump[win_idx[s]];
      w_store[s] = is_store[win_idx[s]];
      if (jump_hit && jump_slot == 2'(s))
        redir_pc = tgt_q[win_idx[s]];
    end
  end

  rob_retire_select #(
    .COMMIT_W (COMMIT_W)
  ) u_sel (
    .busy      (w_busy),
    .ready     (w_ready),
    .jump      (w_jump),
    .is_store  (w_store),
    .ret_cnt   (ret_cnt),
    .jump_hit  (jump_hit),
    .jump_slot (jump_slot)
  );

  logic [ID_W-1:0]   q_id  [2];
  logic              q_rdy [2];
  logic [DATA_W-1:0] q_dat [2];
  logic [IDX_W-1:0]  q_idx [2];

  assign q_id[0]  = q1_id;
  assign q_id[1]  = q2_id;
  assign q1_ready = q_rdy[0];
  assign q2_ready = q_rdy[1];
  assign q1_data  = q_dat[0];
  assign q2_data  = q_dat[1];

  // Later ports overwrite earlier ones, matching write-back priority.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      q_idx[q] = IDX_W'(q_id[q] - ID_W'(1));
      q_rdy[q] = 1'b0;
      q_dat[q] = '0;
      if (q_id[q] != ID_W'(ZERO_ROB_ID)) begin
        q_rdy[q] = ready[q_idx[q]];
        q_dat[q] = data_q[q_idx[q]];
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && busy[q_idx[q]] &&
              wb_id[p*ID_W +: ID_W] == q_id[q]) begin
            q_rdy[q] = 1'b1;
            q_dat[q] = wb_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      busy            <= '0;
      ready           <= '0;
      commit_valid    <= '0;
      commit_rd       <= '0;
      commit_id       <= '0;
      commit_data     <= '0;
      commit_is_store <= '0;
      redirect_valid  <= 1'b0;
      redirect_pc     <= '0;
    end else begin
      for (int s = 0; s < COMMIT_W; s++) begin
        if (s < int'(ret_cnt)) begin
          commit_valid[s]                 <= 1'b1;
          commit_rd[s*REG_W +: REG_W]     <= rd_q[win_idx[s]];
          commit_id[s*ID_W +: ID_W]       <=
            ID_W'({1'b0, win_idx[s]}) + ID_W'(1);
          commit_data[s*DATA_W +: DATA_W] <= data_q[win_idx[s]];
          commit_is_store[s]              <= w_store[s];
        end else begin
          commit_valid[s]                 <= 1'b0;
          commit_rd[s*REG_W +: REG_W]     <= '0;
          commit_id[s*ID_W +: ID_W]       <= '0;
          commit_data[s*DATA_W +: DATA_W] <= '0;
          commit_is_store[s]              <= 1'b0;
        end
      end
      redirect_valid <= jump_hit;
      if (jump_hit) redirect_pc <= redir_pc;

      if (jump_hit) begin
        busy  <= '0;
        ready <= '0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (alloc_ok) begin
          busy[tail]     <= 1'b1;
          ready[tail]    <= 1'b0;
          jump[tail]     <= 1'b0;
          is_store[tail] <= alloc_is_store;
          rd_q[tail]     <= alloc_rd;
          data_q[tail]   <= '0;
          tgt_q[tail]    <= '0;
          tail           <= tail + IDX_W'(1);
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i]) begin
            if (st_ready_valid && st_ready_id == ID_W'(i + 1))
              ready[i] <= 1'b1;
            for (int p = 0; p < WB_PORTS; p++) begin
              if (wb_valid[p] &&
                  wb_id[p*ID_W +: ID_W] == ID_W'(i + 1)) begin
                ready[i]  <= 1'b1;
                data_q[i] <= wb_data[p*DATA_W +: DATA_W];
                jump[i]   <= wb_jump[p];
                tgt_q[i]  <= wb_target[p*ADDR_W +: ADDR_W];
              end
            end
          end
        end
        for (int s = 0; s < COMMIT_W; s++) begin
          if (s < int'(ret_cnt)) begin
            busy[win_idx[s]]  <= 1'b0;
            ready[win_idx[s]] <= 1'b0;
          end
        end
        head  <= head + IDX_W'(ret_cnt);
        count <= count + (IDX_W+1)'(alloc_ok)
                       - (IDX_W+1)'(ret_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport.
// Expected values are hand-computed per step.
module tb_rob_multiport;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_is_store;
  logic        alloc_ready;
  logic [4:0]  alloc_id;
  logic [4:0]  q1_id, q2_id;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_data, q2_data;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_id;
  logic [63:0] wb_data;
  logic [1:0]  wb_jump;
  logic [63:0] wb_target;
  logic        st_ready_valid;
  logic [4:0]  st_ready_id;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [9:0]  commit_id;
  logic [63:0] commit_data;
  logic [1:0]  commit_is_store;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rob_multiport dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_rd        (alloc_rd),
    .alloc_is_store  (alloc_is_store),
    .alloc_ready     (alloc_ready),
    .alloc_id        (alloc_id),
    .q1_id           (q1_id),
    .q2_id           (q2_id),
    .q1_ready        (q1_ready),
    .q2_ready        (q2_ready),
    .q1_data         (q1_data),
    .q2_data         (q2_data),
    .wb_valid        (wb_valid),
    .wb_id           (wb_id),
    .wb_data         (wb_data),
    .wb_jump         (wb_jump),
    .wb_target       (wb_target),
    .st_ready_valid  (st_ready_valid),
    .st_ready_id     (st_ready_id),
    .commit_valid    (commit_valid),
    .commit_rd       (commit_rd),
    .commit_id       (commit_id),
    .commit_data     (commit_data),
    .commit_is_store (commit_is_store),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    alloc_valid    = 1'b0;
    wb_valid       = '0;
    wb_jump        = '0;
    st_ready_valid = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic st);
    alloc_valid    = 1'b1;
    alloc_rd       = rd;
    alloc_is_store = st;
    tick();
    alloc_valid    = 1'b0;
  endtask

  task automatic set_wb(input int p, input logic [4:0] id,
                        input logic [31:0] d, input logic j,
                        input logic [31:0] t);
    wb_valid[p]          = 1'b1;
    wb_id[p*5 +: 5]      = id;
    wb_data[p*32 +: 32]  = d;
    wb_jump[p]           = j;
    wb_target[p*32 +: 32] = t;
  endtask

  initial begin
    rst = 1'b1;
    alloc_rd = '0;
    alloc_is_store = 1'b0;
    q1_id = '0;
    q2_id = '0;
    wb_id = '0;
    wb_data = '0;
    wb_target = '0;
    st_ready_id = '0;
    do_reset();

    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_id", alloc_id, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_commit_data", commit_data, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);

    for (int i = 0; i < 15; i++) alloc(5'(i + 1), 1'b0);
    chk("fill15_ready", alloc_ready, 1);
    chk("fill15_id", alloc_id, 16);
    alloc(5'd16, 1'b0);
    chk("full_ready", alloc_ready, 0);
    chk("full_id_wrap", alloc_id, 1);
    alloc(5'd17, 1'b0);
    chk("full_ignore_ready", alloc_ready, 0);
    chk("full_ignore_id", alloc_id, 1);
    chk("full_no_commit", commit_valid, 0);

    do_reset();
    alloc(5'd1, 1'b0);
    alloc(5'd2, 1'b0);
    alloc(5'd3, 1'b0);
    set_wb(0, 5'd3, 32'h30, 1'b0, 32'h0);
    tick();
    chk("ooo_wb3_nocommit", commit_valid, 0);
    clr();
    set_wb(0, 5'd2, 32'h20, 1'b0, 32'h0);
    tick();
    chk("ooo_wb2_nocommit", commit_valid, 0);
    clr();
    set_wb(0, 5'd1, 32'h10, 1'b0, 32'h0);
    tick();
    chk("ooo_wb1_nocommit", commit_valid, 0);
    clr();
    tick();
    chk("ooo_c12_valid", commit_valid, 2'b11);
    chk("ooo_c12_data", commit_data, 64'h00000020_00000010);
    chk("ooo_c12_id", commit_id, 10'h041);
    chk("ooo_c12_rd", commit_rd, 10'h041);
    tick();
    chk("ooo_c3_valid", commit_valid, 2'b01);
    chk("ooo_c3_data", commit_data[31:0], 32'h30);
    chk("ooo_c3_id", commit_id[4:0], 3);
    tick();
    chk("ooo_idle_valid", commit_valid, 0);
    chk("ooo_alloc_id", alloc_id, 4);

    do_reset();
    alloc(5'd1, 1'b0);
    alloc(5'd2, 1'b0);
    alloc(5'd3, 1'b0);
    q1_id = 5'd2;
    q2_id = 5'd3;
    set_wb(1, 5'd2, 32'hABCD, 1'b0, 32'h0);
    #1;
    chk("byp_q1_ready", q1_ready, 1);
    chk("byp_q1_data", q1_data, 32'hABCD);
    chk("byp_q2_ready", q2_ready, 0);
    tick();
    clr();
    set_wb(0, 5'd3, 32'h11, 1'b0, 32'h0);
    set_wb(1, 5'd3, 32'h22, 1'b0, 32'h0);
    tick();
    clr();
    #1;
    chk("stored_q1_ready", q1_ready, 1);
    chk("stored_q1_data", q1_data, 32'hABCD);
    chk("port_prio_q2_data", q2_data, 32'h22);
    chk("head_not_ready", commit_valid, 0);
    q1_id = 5'd0;
    #1;
    chk("id0_ready", q1_ready, 0);
    chk("id0_data", q1_data, 0);
    q2_id = 5'd0;

    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b0);
    set_wb(0, 5'd3, 32'h3, 1'b0, 32'h0);
    set_wb(1, 5'd4, 32'h4, 1'b0, 32'h0);
    tick();
    clr();
    set_wb(0, 5'd1, 32'h5, 1'b0, 32'h0);
    set_wb(1, 5'd2, 32'h6, 1'b1, 32'h1000);
    tick();
    clr();
    chk("jmp_pre_commit", commit_valid, 0);
    alloc_valid = 1'b1;
    alloc_rd = 5'd9;
    tick();
    alloc_valid = 1'b0;
    chk("jmp_commit_valid", commit_valid, 2'b11);
    chk("jmp_commit_id", commit_id, 10'h041);
    chk("jmp_commit_data", commit_data, 64'h00000006_00000005);
    chk("jmp_redirect_valid", redirect_valid, 1);
    chk("jmp_redirect_pc", redirect_pc, 32'h1000);
    chk("jmp_alloc_id", alloc_id, 1);
    chk("jmp_alloc_ready", alloc_ready, 1);
    tick();
    chk("jmp_redirect_pulse", redirect_valid, 0);
    chk("jmp_flushed_commit", commit_valid, 0);
    alloc(5'd7, 1'b0);
    chk("post_flush_alloc_id", alloc_id, 2);

    do_reset();
    alloc(5'd0, 1'b1);
    alloc(5'd0, 1'b1);
    st_ready_valid = 1'b1;
    st_ready_id = 5'd2;
    tick();
    st_ready_id = 5'd1;
    tick();
    st_ready_valid = 1'b0;
    chk("st_pre_commit", commit_valid, 0);
    tick();
    chk("st1_valid", commit_valid, 2'b01);
    chk("st1_is_store", commit_is_store, 2'b01);
    chk("st1_id", commit_id[4:0], 1);
    chk("st1_data", commit_data[31:0], 0);
    tick();
    chk("st2_valid", commit_valid, 2'b01);
    chk("st2_is_store", commit_is_store, 2'b01);
    chk("st2_id", commit_id[4:0], 2);
    tick();
    chk("st_idle", commit_valid, 0);

    do_reset();
    for (int i = 0; i < 5; i++) alloc(5'(i + 1), 1'b0);
    set_wb(0, 5'd5, 32'h55, 1'b0, 32'h0);
    set_wb(1, 5'd4, 32'h44, 1'b0, 32'h0);
    tick();
    clr();
    set_wb(0, 5'd3, 32'h33, 1'b0, 32'h0);
    set_wb(1, 5'd2, 32'h22, 1'b0, 32'h0);
    tick();
    clr();
    set_wb(0, 5'd1, 32'h11, 1'b0, 32'h0);
    tick();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_commit", commit_valid, 0);
    chk("mid_rst_alloc_id", alloc_id, 1);
    chk("mid_rst_alloc_ready", alloc_ready, 1);
    tick();
    chk("mid_rst_after", commit_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
